// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the KxK line-buffer convolver.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD_K,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  // Wide enough for any accumulator this block can be configured with.
  localparam int unsigned SAT_W = 160;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned k);
    return 2 * dw + $clog2(k * k);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row line buffers plus KxK window; exposes the window including the pixel now arriving.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int K     = 3,
  parameter int MAX_W = 16,
  parameter int DIM_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [DW-1:0]      pixel,
  input  logic [DIM_W-1:0]   width,
  output logic [K*K*DW-1:0]  win_flat,
  output logic               win_valid,
  output logic [DIM_W-1:0]   ix,
  output logic [DIM_W-1:0]   iy
);

  localparam int LW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  logic [DW-1:0] win_q [K][K];
  logic [DW-1:0] win_d [K][K];
  logic [DW-1:0] col   [K];

  // Row buffers are indexed by column, so each slot holds one pixel per older row.
  generate
    if (K > 1) begin : g_rows
      logic [DW-1:0] lb [K-1][MAX_W];

      always_comb begin
        for (int unsigned r = 0; r < K - 1; r++) col[r] = lb[r][LW'(ix)];
        col[K-1] = pixel;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int unsigned r = 0; r < K - 1; r++)
            for (int unsigned d = 0; d < MAX_W; d++) lb[r][d] <= '0;
        end else if (in_valid) begin
          for (int unsigned r = 0; r < K - 2; r++) lb[r][LW'(ix)] <= lb[r+1][LW'(ix)];
          lb[K-2][LW'(ix)] <= pixel;
        end
      end
    end else begin : g_norows
      always_comb col[0] = pixel;
    end
  endgenerate

  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = col[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++) win_flat[(r*K+c)*DW +: DW] = win_d[r][c];
  end

  assign win_valid = in_valid && (int'(iy) >= K - 1) && (int'(ix) >= K - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ix <= '0;
      iy <= '0;
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++) win_q[r][c] <= '0;
    end else begin
      if (clr) begin
        ix <= '0;
        iy <= '0;
      end else if (in_valid) begin
        if (ix == width - DIM_W'(1)) begin
          ix <= '0;
          iy <= iy + DIM_W'(1);
        end else begin
          ix <= ix + DIM_W'(1);
        end
      end
      if (in_valid) win_q <= win_d;
    end
  end

endmodule

// File: rtl/conv2d_kxk_lb.sv
// KxK signed convolver between scratchpads A (tile), B (kernel) and C (output).
// Build option CONV_RELU_EN clamps negative results to zero before the C write.
module conv2d_kxk_lb
  import conv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int K     = 3,
  parameter int MAX_W = 16,
  parameter int DIM_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stride2,
  input  logic [AW-1:0]    base_a,
  input  logic [AW-1:0]    base_b,
  input  logic [AW-1:0]    base_c,
  input  logic [DIM_W-1:0] tile_w,
  input  logic [DIM_W-1:0] tile_h,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             a_en,
  output logic             a_we,
  output logic [AW-1:0]    a_addr,
  output logic [DW-1:0]    a_di,
  input  logic [DW-1:0]    a_dout,
  output logic             b_en,
  output logic             b_we,
  output logic [AW-1:0]    b_addr,
  output logic [DW-1:0]    b_di,
  input  logic [DW-1:0]    b_dout,
  output logic             c_en,
  output logic             c_we,
  output logic [AW-1:0]    c_addr,
  output logic [DW-1:0]    c_di,
  input  logic [DW-1:0]    c_dout
);

  localparam int CW   = 2 * DIM_W;
  localparam int PW   = 2 * DW;
  localparam int ACCW = acc_width(DW, K);
  localparam int KIW  = (K * K > 1) ? $clog2(K * K) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             stride_r;
  logic [AW-1:0]    base_a_r, base_b_r, base_c_r;
  logic [DIM_W-1:0] w_r, h_r;
  logic [CW-1:0]    npix;
  logic             accept;
  logic             bad_geom;

  logic             a_vld, b_vld;
  logic [KIW-1:0]   b_idx;
  logic [DW-1:0]    kreg [K*K];
  logic [CW-1:0]    oc;

  logic [K*K*DW-1:0] win_flat;
  logic              win_valid;
  logic [DIM_W-1:0]  lb_ix, lb_iy, rel_x, rel_y;
  logic              wr;

  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc;
  logic signed [SAT_W-1:0] sat_full;
  logic [DW-1:0]           res;
  logic                    unused_c_dout;

  assign a_we = 1'b0;
  assign b_we = 1'b0;
  assign a_di = '0;
  assign b_di = '0;
  assign c_we = c_en;
  assign unused_c_dout = ^c_dout;

  assign accept   = (state == IDLE) && start;
  assign npix     = CW'(w_r) * CW'(h_r);
  assign bad_geom = (int'(w_r) < K) || (int'(h_r) < K) || (int'(w_r) > MAX_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      a_en     <= 1'b0;
      a_addr   <= '0;
      b_en     <= 1'b0;
      b_addr   <= '0;
      cnt      <= '0;
      stride_r <= 1'b0;
      base_a_r <= '0;
      base_b_r <= '0;
      base_c_r <= '0;
      w_r      <= '0;
      h_r      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            stride_r <= stride2;
            base_a_r <= base_a;
            base_b_r <= base_b;
            base_c_r <= base_c;
            w_r      <= tile_w;
            h_r      <= tile_h;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (bad_geom) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            b_en   <= 1'b1;
            b_addr <= base_b_r;
            cnt    <= '0;
            state  <= LOAD_K;
          end
        end
        LOAD_K: begin
          if (cnt == CW'(K * K - 1)) begin
            b_en   <= 1'b0;
            a_en   <= 1'b1;
            a_addr <= base_a_r;
            cnt    <= '0;
            state  <= STREAM;
          end else begin
            cnt    <= cnt + CW'(1);
            b_addr <= b_addr + AW'(1);
          end
        end
        STREAM: begin
          if (cnt == npix - CW'(1)) begin
            a_en  <= 1'b0;
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt    <= cnt + CW'(1);
            a_addr <= a_addr + AW'(1);
          end
        end
        DRAIN: begin
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  conv_line_buffer #(
    .DW   (DW),
    .K    (K),
    .MAX_W(MAX_W),
    .DIM_W(DIM_W)
  ) u_lb (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (accept),
    .in_valid (a_vld),
    .pixel    (a_dout),
    .width    (w_r),
    .win_flat (win_flat),
    .win_valid(win_valid),
    .ix       (lb_ix),
    .iy       (lb_iy)
  );

  assign rel_x = lb_ix - DIM_W'(K - 1);
  assign rel_y = lb_iy - DIM_W'(K - 1);
  assign wr    = win_valid && (!stride_r || (!rel_x[0] && !rel_y[0]));

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int unsigned i = 0; i < K * K; i++) begin
      prod = PW'(signed'(win_flat[i*DW +: DW])) * PW'(signed'(kreg[i]));
      acc  = acc + ACCW'(prod);
    end
  end

  always_comb begin
    sat_full = sat_signed(SAT_W'(acc), DW);
    res      = sat_full[DW-1:0];
`ifdef CONV_RELU_EN
    if (res[DW-1]) res = '0;
`else
`endif
  end

  // Outputs are written in raster order, so a running count gives base_c + oy*OW + ox.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
      b_idx  <= '0;
      c_en   <= 1'b0;
      c_addr <= '0;
      c_di   <= '0;
      oc     <= '0;
      for (int unsigned i = 0; i < K * K; i++) kreg[i] <= '0;
    end else begin
      a_vld <= a_en;
      b_vld <= b_en;
      b_idx <= KIW'(cnt);
      for (int unsigned i = 0; i < K * K; i++)
        if (b_vld && (b_idx == KIW'(i))) kreg[i] <= b_dout;
      if (accept) oc <= '0;
      else if (wr) oc <= oc + CW'(1);
      c_en <= wr;
      if (wr) begin
        c_addr <= base_c_r + AW'(oc);
        c_di   <= res;
      end
    end
  end

endmodule

// File: doc/conv2d_kxk_lb.md
Name: conv2d_kxk_lb

Overview:
- Parametrised successor to the fixed 3x3 line-buffer convolver: square KxK kernel, signed data, selectable stride 1/2, valid-only padding.
- Sits between three single-port scratchpads (A = input tile, B = kernel, C = output), each with 1-cycle read latency.
- Host pulses start; block loads the kernel, streams the tile once in row-major order, and writes outputs row-major to C.

Parameters:
- DW, 32, data word width (A, B, C), signed two's complement.
- AW, 8, scratchpad address width.
- K, 3, kernel size; odd, legal range 1..5.
- MAX_W, 16, maximum tile width; sets line-buffer depth.
- DIM_W, 5, width of the tile_w/tile_h ports.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- stride2  in  1  0 = stride 1, 1 = stride 2; latched at start.
- base_a, base_b, base_c  in  AW  scratchpad base addresses; latched at start.
- tile_w, tile_h  in  DIM_W  input tile dimensions; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky until next start; high for an illegal geometry.
- a_en, a_we  out  1  A enable / write enable (a_we is always 0).
- a_addr  out  AW; a_di  out  DW (always 0); a_dout  in  DW.
- b_en, b_we, b_addr, b_di, b_dout: same as the A set, for B.
- c_en, c_we, c_addr, c_di, c_dout: same as the A set, for C; c_dout is unused.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, kernel registers and line buffers cleared.
- FSM:
  - IDLE -> CHECK on start.
  - CHECK (1 cycle): if tile_w<K, tile_h<K or tile_w>MAX_W, set err, go to FIN with no memory access; otherwise go to LOAD_K.
  - LOAD_K: issue K*K B reads, one per cycle, at base_b+0..K*K-1; each word is captured into kernel register k[i] the cycle after its address. Then go to STREAM.
  - STREAM: issue W*H A reads, one per cycle, at base_a+0..W*H-1; each pixel arrives the next cycle. Pixels shift through K-1 row line buffers (depth MAX_W) and a KxK window register.
  - DRAIN: 2 cycles to flush the pipeline.
  - FIN: done=1 and busy=0 in the same cycle; then return to IDLE.
- Output qualification:
  - A pixel at (iy,ix) completes a window when iy>=K-1 and ix>=K-1, and, if stride2, (iy-K+1) and (ix-K+1) are both even.
  - OW = (W-K)/S+1 and OH = (H-K)/S+1, where S is the stride.
- Latency: the C write for output (oy,ox) occurs exactly 2 cycles after the A read of pixel (oy*S+K-1, ox*S+K-1) is issued. c_addr = base_c + oy*OW + ox.
- Arithmetic:
  - Full-precision signed products, summed in an accumulator of 2*DW+ceil(log2(K*K)) bits.
  - The sum saturates to the signed DW range before the write.
  - Window tap (r,c) multiplies k[r*K+c]; r=0 is the oldest row.
- Addresses wrap modulo 2^AW; there is no bounds check against the scratchpad.
- Boundaries:
  - start while busy is ignored.
  - Configuration inputs changing mid-run have no effect.
  - K=1 needs no line buffer; OW=W and OH=H at stride 1.
  - A window that straddles a row boundary never produces a write.
- reset_n low mid-run aborts immediately: all enables drop asynchronously, no done pulse, state returns to IDLE. C contents already written are kept.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: the saturated result is clamped to 0 when negative, before the C write.
- Undefined: signed saturated result is written as-is.
- Timing is identical in both builds.

Decomposition:
- Package conv_pkg:
  - FSM state enum (IDLE, CHECK, LOAD_K, STREAM, DRAIN, FIN).
  - Accumulator-width function.
  - Signed saturate helper.
- One natural sub-module, conv_line_buffer: K-1 row FIFOs of depth MAX_W plus the KxK window shift register, exposing the flattened window and a window-valid flag.
- The MAC tree and FSM stay in the top module.

Test Plan:
- 5x5 ramp A=0..24, K=3, B[0]=1, others 0, stride 1 -> C = 0 1 2 / 5 6 7 / 10 11 12; done 1 cycle after last write; no other C writes.
- Same A, B all 1, stride 1 -> C = 54 63 72 / 99 108 117 / 144 153 162.
- Same A, B all 1, stride2=1 -> 2x2 output, C = 54 72 / 144 162 at base_c+0..3.
- tile_w=2 -> err=1 and done within 3 cycles of start; no A/B/C enables; err clears on next legal start.
- A all 0x7FFFFFFF, B all 1 -> every C = 0x7FFFFFFF (saturated). B all -1 with CONV_RELU_EN -> every C = 0; without the macro -> every C = 0x80000000.
- reset_n pulsed low mid-STREAM -> outputs 0 immediately, no done; a restart then produces correct results.
